// File: rtl/fsm_pkg.sv
// Shared definitions for the bit-serial datapath: serializer state encoding
// and the bit-order select helper also used by the matching deserializer.
package fsm_pkg;

  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_t;

  // Picks the bit that leaves (or enters) the word next for the chosen order.
  function automatic logic ser_pick(input logic msb_first,
                                    input logic msb,
                                    input logic lsb);
    return msb_first ? msb : lsb;
  endfunction

endpackage

// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out stage: takes WIDTH-bit words on a valid/ready
// handshake and emits one registered bit per clock, gapless across words.
module piso_bit_serializer
  import fsm_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_bit,
  output logic             out_valid,
  output logic             out_last,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  ser_state_t       state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             out_bit_reg, out_bit_next;
  logic             handshake;
  logic             cnt_at_last;

  assign cnt_at_last = (cnt_reg == CNT_LAST);
  assign in_ready    = rstn && ((state_reg == SER_IDLE) || cnt_at_last);
  assign handshake   = in_valid && in_ready;

  assign out_bit   = out_bit_reg;
  assign out_valid = (state_reg == SER_SHIFT);
  assign busy      = out_valid;
  assign out_last  = rstn && out_valid && cnt_at_last;

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    cnt_next     = cnt_reg;
    out_bit_next = out_bit_reg;

    case (state_reg)
      SER_IDLE: begin
        cnt_next = '0;
        if (handshake) begin
          state_next   = SER_SHIFT;
          shift_next   = in_data;
          out_bit_next = ser_pick(MSB_FIRST, in_data[WIDTH-1], in_data[0]);
        end else begin
          out_bit_next = IDLE_BIT;
        end
      end

      SER_SHIFT: begin
        if (!cnt_at_last) begin
          // Current bit always sits at the outgoing end of shift_reg.
          shift_next   = MSB_FIRST ? {shift_reg[WIDTH-2:0], 1'b0}
                                   : {1'b0, shift_reg[WIDTH-1:1]};
          cnt_next     = cnt_reg + 1'b1;
          out_bit_next = ser_pick(MSB_FIRST, shift_next[WIDTH-1], shift_next[0]);
        end else if (handshake) begin
          shift_next   = in_data;
          cnt_next     = '0;
          out_bit_next = ser_pick(MSB_FIRST, in_data[WIDTH-1], in_data[0]);
        end else begin
          state_next   = SER_IDLE;
          cnt_next     = '0;
          out_bit_next = IDLE_BIT;
        end
      end

      default: begin
        state_next   = SER_IDLE;
        cnt_next     = '0;
        out_bit_next = IDLE_BIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg   <= SER_IDLE;
      shift_reg   <= '0;
      cnt_reg     <= '0;
      out_bit_reg <= IDLE_BIT;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      cnt_reg     <= cnt_next;
      out_bit_reg <= out_bit_next;
    end
  end

endmodule
